// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its write-side loader.
// Holds the default memory geometry and the loader state encoding.
package imem_pkg;

  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int INSTR_W          = 32;
  localparam int BYTES_PER_WORD   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart assembly at lane 0 (start of a new load)
//   byte_fire   : a stream byte transfers this cycle
//   byte_data   : the byte being transferred
//   lane        : lane the next byte will land in (0..3)
//   word_valid  : one-cycle pulse, the cycle after the lane-3 byte
//   word_data   : last completed word, held until the next one completes
module instr_mem_loader_byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_fire,
  input  logic [7:0]         byte_data,
  output logic [1:0]         lane,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word_data
);

  // Only lanes 0..2 need storage; the lane-3 byte goes straight into the word.
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        asm_q, asm_d;
  logic               word_valid_q, word_valid_d;
  logic [INSTR_W-1:0] word_data_q, word_data_d;

  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    if (clear) begin
      lane_d = 2'd0;
      asm_d  = '0;
    end else if (byte_fire) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0: asm_d[7:0]   = byte_data;
        2'd1: asm_d[15:8]  = byte_data;
        2'd2: asm_d[23:16] = byte_data;
        default: begin
          word_valid_d = 1'b1;
          word_data_d  = {byte_data, asm_q};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= 2'd0;
      asm_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
    end
  end

  assign lane       = lane_q;
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Write-side loader for the instruction memory. Takes a byte stream, packs
// little-endian 32-bit words and writes them at consecutive word addresses.
// Byte handshake: a byte transfers on every rising edge where byte_valid and
// byte_ready are both high; byte_data is ignored otherwise, and byte_ready
// never depends on byte_valid.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start, len_words        : begin a load of len_words words (IDLE only)
//   byte_valid/ready/data   : input byte stream
//   wr_en, wr_addr, wr_data : one-cycle write strobe per word into the memory
//   busy                    : load in progress
//   done                    : one-cycle pulse when the load is complete
//   err                     : sticky, set by a start with len_words > DEPTH_WORDS
//   word_count              : words written in the current load
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   len_words,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [31:0]        wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   word_count
);

  loader_state_e      state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               all_in_q, all_in_d;   // every byte of the load accepted

  logic               byte_fire;
  logic               lane3_fire;
  logic               packer_clear;
  logic [1:0]         lane;
  logic [CNT_W-1:0]   last_idx;

  assign byte_ready = (state_q == LOAD) && !all_in_q;
  assign byte_fire  = byte_valid && byte_ready;
  assign lane3_fire = byte_fire && (lane == 2'd3);
  assign last_idx   = len_q - CNT_W'(1);

  instr_mem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .byte_fire  (byte_fire),
    .byte_data  (byte_data),
    .lane       (lane),
    .word_valid (wr_en),
    .word_data  (wr_data)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    wr_addr_d    = wr_addr_q;
    done_d       = 1'b0;
    err_d        = err_q;
    all_in_d     = all_in_q;
    packer_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words > CNT_W'(DEPTH_WORDS)) begin
            err_d = 1'b1;
          end else begin
            err_d        = 1'b0;
            word_count_d = '0;
            packer_clear = 1'b1;
            if (len_words == '0) begin
              done_d = 1'b1;
            end else begin
              len_d    = len_words;
              all_in_d = 1'b0;
              state_d  = LOAD;
            end
          end
        end
      end
      LOAD: begin
        // word_count already holds this word's index when its last byte
        // arrives: the previous write retired at least three cycles earlier.
        if (lane3_fire) begin
          wr_addr_d = BASE_ADDR + (32'(word_count_q) << 2);
          if (word_count_q == last_idx) all_in_d = 1'b1;
        end
        if (wr_en) begin
          word_count_d = word_count_q + CNT_W'(1);
          if (word_count_q == last_idx) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      wr_addr_q    <= BASE_ADDR;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      all_in_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      wr_addr_q    <= wr_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      all_in_q     <= all_in_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign busy       = (state_q == LOAD);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader with an 8-word memory. Expected words and
// addresses come from the byte list the bench sends; a bench-side memory
// array captures every write for read-back comparison.
module tb_instr_mem_loader;

  localparam int          DEPTH = 8;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] word_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfer = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;
  int wr_seen = 0;
  int done_seen = 0;

  int          exp_wr_cyc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] model_mem[DEPTH];
  logic [31:0] mem[DEPTH];

  instr_mem_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the handshake is judged on the inputs as they stand now, then
  // outputs are observed at the following falling edge.
  task automatic tick();
    logic fire;
    int   exp_c;
    fire = byte_valid && byte_ready && !rst;
    @(negedge clk);
    cyc++;
    if (fire) begin
      xfer++;
      last_xfer_cyc = cyc;
      if (xfer % 4 == 0) exp_wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        exp_c = -1;
        if (exp_wr_cyc_q.size() != 0) exp_c = exp_wr_cyc_q.pop_front();
        check("wr_cycle", cyc, exp_c);
        check("wr_addr", wr_addr, exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_q.pop_front());
        mem[wr_addr[4:2]] = wr_data;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_ready", tag), 32'(byte_ready), 32'd0);
    check($sformatf("%s_wr_en", tag), 32'(wr_en), 32'd0);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_done", tag), 32'(done), 32'd0);
    check($sformatf("%s_err", tag), 32'(err), 32'd0);
    check($sformatf("%s_addr", tag), wr_addr, BASE);
    check($sformatf("%s_data", tag), wr_data, 32'd0);
    check($sformatf("%s_count", tag), 32'(word_count), 32'd0);
  endtask

  task automatic random_stim(input int len);
    stim_q.delete();
    for (int i = 0; i < 4 * len; i++) stim_q.push_back(8'($urandom));
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic run_load(input int len, input int mode);
    int          idx;
    int          guard;
    logic [31:0] w;
    exp_q.delete();
    exp_addr_q.delete();
    exp_wr_cyc_q.delete();
    foreach (mem[i]) mem[i] = 32'd0;
    xfer = 0;
    wr_seen = 0;
    done_seen = 0;
    for (int i = 0; i < len; i++) begin
      w = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
      model_mem[i] = w;
      exp_q.push_back(w);
      exp_addr_q.push_back(BASE + 32'(4 * i));
    end
    start = 1'b1;
    len_words = CW'(len);
    tick();
    start = 1'b0;
    len_words = CW'($urandom_range(0, 15));
    check("load_busy", 32'(busy), 32'd1);
    check("load_err", 32'(err), 32'd0);
    check("load_count0", 32'(word_count), 32'd0);
    idx = 0;
    guard = 0;
    while (idx < 4 * len && guard < 400) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (guard % 2 == 0);
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      byte_data = byte_valid ? stim_q[idx] : 8'($urandom);
      start = (guard == 2);   // must be ignored mid-load
      check("ready_mid", 32'(byte_ready), 32'd1);
      if (byte_valid && byte_ready) idx++;
      tick();
      guard++;
    end
    start = 1'b0;
    check("load_bytes", 32'(idx == 4 * len), 32'd1);
    check("ready_fall", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data = 8'($urandom);
    guard = 0;
    while (done_seen == 0 && guard < 10) begin
      tick();
      guard++;
    end
    byte_valid = 1'b0;
    check("done_seen", done_seen, 1);
    check("done_cycle", done_cyc, last_xfer_cyc + 1);
    check("wr_count", wr_seen, len);
    check("wr_pending", exp_q.size(), 0);
    check("xfer_count", xfer, 4 * len);
    check("word_count", 32'(word_count), len);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("count_hold", 32'(word_count), len);
    for (int i = 0; i < len; i++) check($sformatf("mem_%0d", i), mem[i], model_mem[i]);
  endtask

  initial begin
    int len;
    rst = 1'b1;
    start = 1'b0;
    len_words = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    tick();
    tick();
    check_reset("por");
    rst = 1'b0;
    tick();

    // two words, back-to-back
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0);
    check("t1_w0", mem[0], 32'h0000_0013);
    check("t1_w1", mem[1], 32'h0010_0093);

    // same stream, valid toggling
    run_load(2, 1);
    check("t2_w0", mem[0], 32'h0000_0013);
    check("t2_w1", mem[1], 32'h0010_0093);

    // length overflow
    wr_seen = 0;
    done_seen = 0;
    start = 1'b1;
    len_words = CW'(DEPTH + 1);
    tick();
    start = 1'b0;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    byte_valid = 1'b1;
    repeat (4) begin
      tick();
      check("ovf_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    check("ovf_no_wr", wr_seen, 0);
    check("ovf_no_done", done_seen, 0);
    check("ovf_err_sticky", 32'(err), 32'd1);
    random_stim(1);
    run_load(1, 0);

    // zero-length load
    wr_seen = 0;
    start = 1'b1;
    len_words = '0;
    byte_valid = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_ready", 32'(byte_ready), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    byte_valid = 1'b0;
    check("len0_pulse", 32'(done), 32'd0);
    check("len0_no_wr", wr_seen, 0);
    check("len0_count", 32'(word_count), 32'd0);

    // leave non-reset values on the outputs, then reset mid-word
    random_stim(3);
    run_load(3, 2);
    exp_q.delete();
    exp_addr_q.delete();
    exp_wr_cyc_q.delete();
    xfer = 0;
    wr_seen = 0;
    start = 1'b1;
    len_words = CW'(1);
    tick();
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h11;
    tick();
    byte_data = 8'h22;
    tick();
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset("mid");
    rst = 1'b0;
    repeat (6) tick();
    check("mid_no_wr", wr_seen, 0);
    check("mid_idle", 32'(busy), 32'd0);
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0);
    check("fresh_w0", mem[0], 32'hDDCC_BBAA);

    // full depth, word i = i*4
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      stim_q.push_back(8'(i * 4));
      stim_q.push_back(8'h00);
      stim_q.push_back(8'h00);
      stim_q.push_back(8'h00);
    end
    run_load(DEPTH, 0);
    for (int i = 0; i < DEPTH; i++) check($sformatf("full_%0d", i), mem[i], 32'(i * 4));

    // random loads
    repeat (4) begin
      len = int'($urandom_range(1, DEPTH));
      random_stim(len);
      run_load(len, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
